obi_sbr_mem: RTL and testbench
==============================

Name: obi_sbr_mem

Overview:
- OBI subordinate that terminates the A/R channels driven by the single-transfer OBI manager.
- Provides a small word-addressed memory with per-byte write enables.
- Inserts a programmable number of address-phase wait states before grant.
- Buffers responses in a small FIFO, so the R channel honours rready back-pressure and up to RSP_DEPTH transactions may be outstanding.
- Used as the bring-up/verification target for the manager and as a scratch memory in the subsystem.

Parameters:
- ADDR_WIDTH, 32, address width; 32 or 64.
- DATA_WIDTH, 32, data width; 32 or 64; byte lanes = DATA_WIDTH/8.
- DEPTH, 16, number of DATA_WIDTH words; power of two, at least 2.
- GNT_WAIT, 0, wait cycles between req rising and gnt; range 0..15.
- RSP_DEPTH, 2, response FIFO entries; power of two, at least 1.

Ports:
- clk_i  in  1  clock
- reset_ni  in  1  reset, asynchronous, active-low
- obi_req_i  in  1  address-phase request
- obi_gnt_o  out  1  address-phase grant
- obi_addr_i  in  ADDR_WIDTH  byte address
- obi_we_i  in  1  1 = write, 0 = read
- obi_be_i  in  DATA_WIDTH/8  byte enables
- obi_wdata_i  in  DATA_WIDTH  write data
- obi_rvalid_o  out  1  response valid
- obi_rready_i  in  1  response ready
- obi_rdata_o  out  DATA_WIDTH  read data; 0 for writes and for errors
- obi_err_o  out  1  response error
- busy_o  out  1  high when any response is outstanding (FIFO not empty)

Behaviour:
- Reset: asynchronous, active-low, clock clk_i.
  - All outputs 0; FIFO empty; wait counter 0; FSM in IDLE; all memory words cleared to 0.
  - Reset mid-transaction drops every queued response; no rvalid appears after reset release until a new accept.
- Accept condition: obi_req_i && obi_gnt_o.
- Address decode:
  - Word index = obi_addr_i[log2(DEPTH)+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)].
  - In range iff obi_addr_i < DEPTH*DATA_WIDTH/8. Low byte-offset bits are ignored.
- Grant FSM (states IDLE, WAIT, GRANT):
  - IDLE, req=0: stay.
  - IDLE, req=1: go to GRANT if GNT_WAIT==0, else go to WAIT with counter=1.
  - WAIT: counter increments each cycle; on counter==GNT_WAIT go to GRANT.
  - GRANT: obi_gnt_o = obi_req_i && !fifo_full, combinational. On accept return to IDLE; if req stays high, GNT_WAIT applies again to the next transfer.
  - GNT_WAIT==0: gnt is combinational from req in the same cycle as req, including back-to-back transfers.
  - req deasserted in WAIT (protocol violation): return to IDLE, counter cleared.
- Write:
  - On accept, each byte lane with be=1 is written at that clock edge; be=0 lanes keep their old value.
  - An out-of-range write modifies nothing and queues err=1.
- Read:
  - Memory word sampled at the accept edge and pushed to the FIFO with err=0.
  - Out-of-range read pushes rdata=0, err=1.
  - A read accepted after a write to the same word returns the new data.
- Response FIFO:
  - Entry = {rdata, err}. Push on accept; pop on obi_rvalid_o && obi_rready_i.
  - obi_rvalid_o = !empty.
  - Minimum latency: rvalid in the cycle after accept.
  - rdata/err are held stable while rvalid && !rready.
  - Full: gnt forced low even if a pop happens in the same cycle (no pass-through).
  - Simultaneous push and pop when not full: occupancy unchanged.
  - Pointers wrap modulo RSP_DEPTH; responses are returned strictly in accept order.

Optional Feature:
- Macro OBI_SBR_MISALIGN_ERR_EN.
- Defined: an accept whose byte-offset bits are nonzero is treated as an error. The write is suppressed and the response is rdata=0, err=1.
- Not defined: offset bits are ignored and the access proceeds to the aligned word.

Decomposition:
- Package obi_sbr_pkg:
  - grant FSM state enum (IDLE, WAIT, GRANT);
  - parameterised response entry struct {rdata, err};
  - localparams BE_WIDTH = DATA_WIDTH/8 and OFFS_BITS = log2(BE_WIDTH).
- One sub-module, obi_sbr_rsp_fifo:
  - generic synchronous FIFO with push/pop/full/empty;
  - reset-cleared pointers and count.

Test Plan:
- GNT_WAIT=0, rready=1: write 0xDEADBEEF to 0x8 with be=0xF, then read 0x8 → gnt in the req cycle both times; write response rdata=0, err=0; read response 0xDEADBEEF one cycle after its accept.
- Partial write: word at 0x4 = 0x11223344, write 0xAABBCCDD with be=0x5 → subsequent read of 0x4 returns 0x11BB33DD.
- GNT_WAIT=3: req held from cycle 0 → gnt first high in cycle 3; exactly one accept.
- Out of range, DEPTH=16: read 0x40 → err=1, rdata=0. Write 0x40 → err=1 and a full scan of all 16 words shows no change.
- RSP_DEPTH=2, rready=0: issue 3 reads → 2 accepted, gnt low on the third. Raise rready → responses drain in order; the third read is granted in the cycle after the first pop.
- Assert reset with 2 responses queued → rvalid=0 immediately; after release no rvalid without a new request, and a read of 0x0 returns 0.

Source files
------------

// File: rtl/obi_sbr_pkg.sv
// Shared types and helpers for the OBI subordinate memory.
// The response entry struct depends on DATA_WIDTH. A package cannot take type
// parameters, so the struct is declared in the top. The package provides
// helpers that derive the byte-lane geometry from the data width.
package obi_sbr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        GRANT
    } gnt_state_e;

    // Wide enough for GNT_WAIT up to 15.
    localparam int unsigned GNT_CNT_W = 4;

    function automatic int unsigned calc_be_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned calc_offs_bits(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/obi_sbr_rsp_fifo.sv
// Generic synchronous FIFO holding R-channel responses in accept order.
// Pointers and occupancy are cleared by the asynchronous active-low reset.
module obi_sbr_rsp_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = slots[rptr];

    // Storage write; contents need no reset because empty gates the output.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking with modulo-DEPTH wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= bump(wptr);
            end
            if (do_pop) begin
                rptr <= bump(rptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/obi_sbr_mem.sv
// OBI subordinate with a word-addressed byte-enabled memory, programmable
// address-phase wait states and a response FIFO for R-channel back-pressure.
// Optional: define OBI_SBR_MISALIGN_ERR_EN to reject accesses whose byte-offset
// bits are nonzero (write suppressed, rdata=0, err=1).
module obi_sbr_mem
    import obi_sbr_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned GNT_WAIT   = 0,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    obi_req_i,
    output logic                    obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   obi_addr_i,
    input  logic                    obi_we_i,
    input  logic [DATA_WIDTH/8-1:0] obi_be_i,
    input  logic [DATA_WIDTH-1:0]   obi_wdata_i,
    output logic                    obi_rvalid_o,
    input  logic                    obi_rready_i,
    output logic [DATA_WIDTH-1:0]   obi_rdata_o,
    output logic                    obi_err_o,
    output logic                    busy_o
);

    localparam int unsigned BE_WIDTH  = calc_be_width(DATA_WIDTH);
    localparam int unsigned OFFS_BITS = calc_offs_bits(DATA_WIDTH);
    localparam int unsigned IDX_BITS  = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic                  err;
    } rsp_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    gnt_state_e            state;
    logic [GNT_CNT_W-1:0]  cnt;
    logic [GNT_CNT_W-1:0]  cnt_next;
    logic [IDX_BITS-1:0]   idx;
    logic                  in_range;
    logic                  acc_err;
    logic                  accept;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  gnt_phase;
    rsp_t                  push_entry;
    rsp_t                  head_entry;

    assign idx      = obi_addr_i[IDX_BITS+OFFS_BITS-1:OFFS_BITS];
    assign in_range = (obi_addr_i < ADDR_WIDTH'(DEPTH * BE_WIDTH));

`ifdef OBI_SBR_MISALIGN_ERR_EN
    assign acc_err = !in_range || (|obi_addr_i[OFFS_BITS-1:0]);
`else
    assign acc_err = !in_range;
`endif

    // With no wait states IDLE grants directly, so back-to-back accepts need no bubble.
    assign gnt_phase = (state == GRANT) || ((GNT_WAIT == 0) && (state == IDLE));
    assign obi_gnt_o = gnt_phase && obi_req_i && !fifo_full;
    assign accept    = obi_req_i && obi_gnt_o;
    assign cnt_next  = cnt + GNT_CNT_W'(1);

    // Grant FSM; reaching GRANT when the next counter value hits GNT_WAIT puts gnt in cycle GNT_WAIT.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (obi_req_i && !accept) begin
                        if (GNT_WAIT <= 1) begin
                            state <= GRANT;
                            cnt   <= '0;
                        end else begin
                            state <= WAIT;
                            cnt   <= GNT_CNT_W'(1);
                        end
                    end
                end
                WAIT: begin
                    if (!obi_req_i) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt_next == GNT_CNT_W'(GNT_WAIT)) begin
                        state <= GRANT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                GRANT: begin
                    if (accept || !obi_req_i) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Memory array: cleared on reset, byte-lane writes on accepted in-range writes.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (accept && obi_we_i && !acc_err) begin
            for (int unsigned j = 0; j < BE_WIDTH; j++) begin
                if (obi_be_i[j]) begin
                    mem[idx][8*j +: 8] <= obi_wdata_i[8*j +: 8];
                end
            end
        end
    end

    // Response formed at accept: read data only for good reads.
    always_comb begin
        push_entry.err   = acc_err;
        push_entry.rdata = (obi_we_i || acc_err) ? '0 : mem[idx];
    end

    obi_sbr_rsp_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk_i),
        .reset_n   (reset_ni),
        .push      (accept),
        .push_data (push_entry),
        .pop       (obi_rready_i),
        .head      (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign obi_rvalid_o = !fifo_empty;
    assign busy_o       = !fifo_empty;
    assign obi_rdata_o  = obi_rvalid_o ? head_entry.rdata : '0;
    assign obi_err_o    = obi_rvalid_o && head_entry.err;

endmodule

// File: tb/tb_obi_sbr_mem.sv
// Scoreboard bench for obi_sbr_mem: the driver updates a reference memory and
// queues expected responses at each accept; a monitor compares on rvalid.
module tb_obi_sbr_mem;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req, gnt, we, rvalid, rready, err, busy;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  be;

    logic        w_req, w_gnt, w_rvalid, w_err, w_busy;
    logic [31:0] w_rdata;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [16];
    int          n_pass  = 0;
    int          n_total = 0;
    bit          rnd_rr  = 1'b0;

    always #5 clk = ~clk;

    obi_sbr_mem #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (16),
        .GNT_WAIT   (0),
        .RSP_DEPTH  (2)
    ) dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .obi_req_i    (req),
        .obi_gnt_o    (gnt),
        .obi_addr_i   (addr),
        .obi_we_i     (we),
        .obi_be_i     (be),
        .obi_wdata_i  (wdata),
        .obi_rvalid_o (rvalid),
        .obi_rready_i (rready),
        .obi_rdata_o  (rdata),
        .obi_err_o    (err),
        .busy_o       (busy)
    );

    obi_sbr_mem #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .DEPTH      (16),
        .GNT_WAIT   (3),
        .RSP_DEPTH  (2)
    ) dut_w (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .obi_req_i    (w_req),
        .obi_gnt_o    (w_gnt),
        .obi_addr_i   (32'h0),
        .obi_we_i     (1'b0),
        .obi_be_i     (4'hF),
        .obi_wdata_i  (32'h0),
        .obi_rvalid_o (w_rvalid),
        .obi_rready_i (1'b1),
        .obi_rdata_o  (w_rdata),
        .obi_err_o    (w_err),
        .busy_o       (w_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour at an accept: update memory, queue the response.
    task automatic accept_model(input logic [31:0] a, input logic w,
                                input logic [3:0] b, input logic [31:0] d);
        exp_t e;
        logic bad;
        int   wi;
        bad = (a >= 32'd64);
`ifdef OBI_SBR_MISALIGN_ERR_EN
        bad = bad || (a % 4 != 0);
`endif
        wi = int'(a % 64) / 4;
        e.err  = bad;
        e.data = 32'h0;
        if (w) begin
            if (!bad) begin
                for (int k = 0; k < 4; k++) begin
                    if (b[k]) ref_mem[wi][8*k +: 8] = d[8*k +: 8];
                end
            end
        end else if (!bad) begin
            e.data = ref_mem[wi];
        end
        exp_q.push_back(e);
    endtask

    // Issue one transfer from posedge+1; returns cycles spent waiting for gnt.
    task automatic do_req(input logic [31:0] a, input logic w, input logic [3:0] b,
                          input logic [31:0] d, input bit lat, output int waits);
        bit got;
        got   = 1'b0;
        waits = 0;
        req   = 1'b1;
        addr  = a;
        we    = w;
        be    = b;
        wdata = d;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (gnt) begin
                got = 1'b1;
                break;
            end
            waits++;
            @(posedge clk);
            #1;
        end
        chk("gnt_seen", {63'd0, got}, 64'd1);
        if (got) accept_model(a, w, b, d);
        @(posedge clk);
        #1;
        req = 1'b0;
        if (lat && got) begin
            @(negedge clk);
            chk("rsp_latency", {63'd0, rvalid}, 64'd1);
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every presented response against the queue head.
    always @(negedge clk) begin
        if (reset_n && rvalid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_spurious", {63'd0, rvalid}, 64'd0);
            end else begin
                chk("rsp_rdata", {32'd0, rdata}, {32'd0, exp_q[0].data});
                chk("rsp_err", {63'd0, err}, {63'd0, exp_q[0].err});
                chk("rsp_busy", {63'd0, busy}, 64'd1);
                if (rready) void'(exp_q.pop_front());
            end
        end
    end

    // Random back-pressure during the random phase.
    always @(posedge clk) begin
        if (rnd_rr) begin
            #1;
            rready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          wt;
        int          n_acc;
        int          n_rsp;
        logic [31:0] ra;
        reset_n = 1'b0;
        req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0;
        rready = 1'b1;
        w_req = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", {63'd0, gnt}, 64'd0);
        chk("reset_rvalid", {63'd0, rvalid}, 64'd0);
        chk("reset_rdata", {32'd0, rdata}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_rvalid", {63'd0, rvalid}, 64'd0);
        chk("post_reset_err", {63'd0, err}, 64'd0);
        @(posedge clk);
        #1;

        // Full-word write then read with zero wait states.
        do_req(32'h8, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, wt);
        chk("wr_gnt_same_cycle", 64'(wt), 64'd0);
        do_req(32'h8, 1'b0, 4'hF, 32'h0, 1'b1, wt);
        chk("rd_gnt_same_cycle", 64'(wt), 64'd0);

        // Partial write with be=0101.
        do_req(32'h4, 1'b1, 4'hF, 32'h11223344, 1'b0, wt);
        do_req(32'h4, 1'b1, 4'h5, 32'hAABBCCDD, 1'b0, wt);
        do_req(32'h4, 1'b0, 4'hF, 32'h0, 1'b0, wt);

        // Out of range read and write, then scan all words.
        do_req(32'h40, 1'b0, 4'hF, 32'h0, 1'b0, wt);
        do_req(32'h40, 1'b1, 4'hF, 32'h55AA55AA, 1'b0, wt);
        for (int i = 0; i < 16; i++) do_req(32'(i * 4), 1'b0, 4'hF, 32'h0, 1'b0, wt);
        repeat (3) @(posedge clk);
        #1;

        // Full FIFO blocks the third read; grant returns only after a pop.
        rready = 1'b0;
        do_req(32'h8, 1'b0, 4'hF, 32'h0, 1'b0, wt);
        do_req(32'h4, 1'b0, 4'hF, 32'h0, 1'b0, wt);
        req = 1'b1; addr = 32'h0; we = 1'b0; be = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_gnt_low", {63'd0, gnt}, 64'd0);
            @(posedge clk);
            #1;
        end
        rready = 1'b1;
        @(negedge clk);
        chk("full_no_passthru", {63'd0, gnt}, 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("gnt_after_pop", {63'd0, gnt}, 64'd1);
        if (gnt) accept_model(32'h0, 1'b0, 4'hF, 32'h0);
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Wait-state instance: req held from cycle 0, gnt in cycle 3, one accept.
        n_acc = 0;
        n_rsp = 0;
        w_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("wait_gnt_cycle", {63'd0, w_gnt}, (c == 3) ? 64'd1 : 64'd0);
            if (w_req && w_gnt) n_acc++;
            @(posedge clk);
            #1;
        end
        w_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (w_req && w_gnt) n_acc++;
            if (w_rvalid) begin
                n_rsp++;
                chk("wait_rsp_rdata", {32'd0, w_rdata}, 64'd0);
                chk("wait_rsp_err", {63'd0, w_err}, 64'd0);
            end
        end
        chk("wait_accepts", 64'(n_acc), 64'd1);
        chk("wait_responses", 64'(n_rsp), 64'd1);
        @(posedge clk);
        #1;

        // Reset with two responses queued.
        do_req(32'h0, 1'b1, 4'hF, 32'hCAFEF00D, 1'b0, wt);
        repeat (3) @(posedge clk);
        #1;
        rready = 1'b0;
        do_req(32'h0, 1'b0, 4'hF, 32'h0, 1'b0, wt);
        do_req(32'h4, 1'b0, 4'hF, 32'h0, 1'b0, wt);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_rvalid_now", {63'd0, rvalid}, 64'd0);
        chk("rst_busy_now", {63'd0, busy}, 64'd0);
        exp_q.delete();
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rready  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("no_rvalid_after_reset", {63'd0, rvalid}, 64'd0);
            @(posedge clk);
            #1;
        end
        do_req(32'h0, 1'b0, 4'hF, 32'h0, 1'b0, wt);

        // Random traffic under random back-pressure.
        rnd_rr = 1'b1;
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 9))
                0: ra = 32'h40 + 32'($urandom_range(0, 63));
                1: ra = $urandom;
                default: ra = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            endcase
            do_req(ra, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 1'b0, wt);
        end
        rnd_rr = 1'b0;
        @(posedge clk);
        #2;
        rready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
        #2;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
